// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: receive-side responder of the toggle request/acknowledge
// multibit handshake. Lives entirely in clk_b. Synchronizes req_tgl,
// captures the held sender word, offers it downstream with valid/ready and
// returns an acknowledge toggle once the word has been consumed.
module cdc_hs_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_b,
    input  logic             rst_n_b,
    input  logic             en,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] mdata_in,
    input  logic             rdy_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] mdata_out,
    output logic             ack_tgl,
    output logic             busy,
    output logic             err_out,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;
    logic                   req_d;
    logic                   req_last;
    logic                   pending;
    logic                   req_edge;

    logic                   vld_nxt;
    logic [WIDTH-1:0]       mdata_nxt;
    logic                   req_last_nxt;
    logic                   ack_nxt;
    logic                   err_nxt;
    logic [CNT_W-1:0]       cnt_nxt;

    assign req_s    = sync[SYNC_STAGES-1];
    assign pending  = req_s ^ req_last;
    assign req_edge = req_s ^ req_d;
    assign busy     = (state == HOLD) | pending;

    // Request toggle synchronizer chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            sync  <= '0;
            req_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], req_tgl};
            req_d <= req_s;
        end
    end

    // State and datapath registers; all next values come from the FSM process below
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            state     <= IDLE;
            vld_out   <= 1'b0;
            mdata_out <= '0;
            req_last  <= 1'b0;
            ack_tgl   <= 1'b0;
            err_out   <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            vld_out   <= vld_nxt;
            mdata_out <= mdata_nxt;
            req_last  <= req_last_nxt;
            ack_tgl   <= ack_nxt;
            err_out   <= err_nxt;
            xfer_cnt  <= cnt_nxt;
        end
    end

    // Next-state logic: capture on pending request in IDLE, release on handshake in HOLD.
    // Reloading req_last from req_s on HOLD exit drops any request that toggled mid-HOLD.
    always_comb begin
        state_nxt    = state;
        vld_nxt      = vld_out;
        mdata_nxt    = mdata_out;
        req_last_nxt = req_last;
        ack_nxt      = ack_tgl;
        err_nxt      = err_out;
        cnt_nxt      = xfer_cnt;
        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (en && pending) begin
                    mdata_nxt    = mdata_in;
                    vld_nxt      = 1'b1;
                    req_last_nxt = req_s;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (req_edge) begin
                    err_nxt = 1'b1;
                end
                if (vld_out && rdy_in) begin
                    vld_nxt      = 1'b0;
                    ack_nxt      = ~ack_tgl;
                    cnt_nxt      = xfer_cnt + CNT_W'(1);
                    req_last_nxt = req_s;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/cdc_hs_rx.md
# cdc_hs_rx

Receive-side responder of the toggle request/acknowledge multibit handshake used by the CDC synchronizer in MCMLPDS mode dmux_en. It sits entirely in the clk_b domain. It synchronizes the sender's request toggle, captures the held multibit word, and presents it downstream with valid/ready. It returns an acknowledge toggle to the clk_a-side initiator once the word has been consumed.

## Interface
- WIDTH, 32: data word width.
- SYNC_STAGES, 2: flops in the req_tgl synchronizer chain; legal values are 2 or more.
- CNT_W, 8: width of the completed-transfer counter.

- clk_b  in  1  receive-domain clock; the only clock of the block.
- rst_n_b  in  1  synchronous, active-low reset.
- en  in  1  capture enable; gates new captures only.
- req_tgl  in  1  request toggle from the clk_a domain; asynchronous to clk_b.
- mdata_in  in  WIDTH  sender data; the sender holds it stable from its req_tgl toggle until it sees ack_tgl toggle.
- rdy_in  in  1  downstream ready.
- vld_out  out  1  mdata_out valid.
- mdata_out  out  WIDTH  captured word.
- ack_tgl  out  1  acknowledge toggle back to the clk_a domain.
- busy  out  1  request pending or word held.
- err_out  out  1  sticky protocol-violation flag.
- xfer_cnt  out  CNT_W  count of completed transfers.

## Operation
- **Synchronizer.** Chain sync[0..SYNC_STAGES-1] samples req_tgl every clk_b edge; its last stage is req_s.
- **Registers.** req_last holds the req_s value of the last accepted request. req_d holds req_s delayed one cycle.
- **Derived signals.** pending = req_s ^ req_last. edge = req_s ^ req_d.
- **FSM state IDLE.** vld_out = 0. If en && pending: mdata_out <= mdata_in, vld_out <= 1, req_last <= req_s, go to HOLD. If en = 0: stay in IDLE and keep pending; no request is lost.
- **FSM state HOLD.** vld_out = 1 and mdata_out stays stable. When vld_out && rdy_in is sampled:
  - vld_out <= 0, ack_tgl <= ~ack_tgl, xfer_cnt <= xfer_cnt + 1, req_last <= req_s, go to IDLE.
  - HOLD completes regardless of en.
- **Protocol violation.** edge = 1 while in HOLD means the sender toggled again before the acknowledge. Then err_out <= 1 and that request is dropped: req_last is reloaded on HOLD exit, so it is never captured and never acknowledged.
- **err_out.** Stays at 1 until reset.
- **busy.** busy = (state == HOLD) | pending. It is combinational from registers.
- **xfer_cnt.** Modulo 2^CNT_W: 2^CNT_W-1 wraps to 0 with no flag.
- **Reset.** When rst_n_b = 0 at a clk_b edge, every register clears: sync chain, req_d, req_last, ack_tgl, vld_out, mdata_out, err_out, xfer_cnt and state (to IDLE).
  - A reset during HOLD discards the word without an acknowledge.
  - The clk_a side must be reset in the same reset window so both toggles restart at 0.

## Timing
- All outputs come from registers except busy.
- **Capture latency.** The first clk_b edge that samples a new req_tgl level is edge 1; req_s shows it after edge SYNC_STAGES. With en = 1 and state IDLE, vld_out rises at edge SYNC_STAGES+1, with mdata_out valid in the same cycle.
- **Handshake.** The transfer happens at the edge where vld_out = rdy_in = 1. At that same edge vld_out falls and ack_tgl toggles. With rdy_in held at 1, vld_out is high for exactly one cycle.
- **Minimum spacing.** There are at least 2 clk_b cycles between accepted words: one HOLD cycle plus one IDLE cycle.
- **Simultaneous events.** A req_s edge in the same cycle as the handshake exit from HOLD is an error (err_out = 1) and that request is dropped.
- **en deassertion.** Dropping en in IDLE delays capture by exactly the cycles en is low. en has no effect in HOLD.

## Test plan
- **Basic transfer.** SYNC_STAGES = 2, rdy_in = 1, en = 1. Toggle req_tgl 0->1 with mdata_in = 0xA5A5_5A5A. Required: vld_out high at edge 3 for exactly 1 cycle, mdata_out = 0xA5A5_5A5A, ack_tgl 0->1 at edge 4, xfer_cnt = 1.
- **Backpressure.** rdy_in = 0 for 5 cycles after vld_out rises. Required: vld_out and mdata_out stable for 5 cycles, ack_tgl unchanged. Then rdy_in = 1: one transfer and ack_tgl toggles.
- **Enable gating.** en = 0 when req_tgl toggles, held low 10 cycles. Required: busy = 1 and vld_out = 0 throughout. vld_out rises 1 cycle after en returns to 1.
- **Protocol violation.** Toggle req_tgl twice (0->1, then 1->0 once req_s = 1) while HOLD with rdy_in = 0. Required: err_out = 1; after the handshake only one transfer is counted and state is IDLE with busy = 0. err_out stays 1 until reset.
- **Counter wrap.** CNT_W = 8, 256 completed handshakes with mdata_in = transfer index. Required: every word is received in order and xfer_cnt = 0 at the end.
- **Reset mid-HOLD.** rst_n_b = 0 for 1 edge while vld_out = 1. Required: all outputs 0 after that edge, ack_tgl not toggled, state IDLE.
